inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit_pkg.sv | 28 ++
 rtl/inst_fetch_unit_fifo.sv | 63 ++++++
 rtl/inst_fetch_unit.sv | 131 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
// Contents: instruction width, HALT opcode, PC step, fetch FSM encoding,
// the fetch-entry layout at the default 16-bit PC width, and a HALT
// decode helper.
package inst_fetch_unit_pkg;

  localparam int         INSTR_W = 16;
  localparam int         PC_W    = 16;
  localparam int         PC_STEP = 2;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } fetch_state_e;

  // Layout of one buffered entry: instruction word above its byte PC.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic is_halt(input logic [3:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: synchronous shift-style FIFO whose entry 0 is always the
// head, so the head output is a plain register (no read mux on the ptr).
// Ports:
//   clock, reset_n  clock / async active-low reset
//   push_i, data_i  write one entry (ignored when full)
//   pop_i           drop the head (ignored when empty)
//   flush_i         empty the FIFO; wins over push and pop
//   head_o          head entry
//   head_vld_o      FIFO not empty
//   count_o         occupancy
module fetch_fifo #(
  parameter int  DEPTH  = 2,
  parameter int  DATA_W = 32,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic              head_vld_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      if (pop_i && cnt_q != '0) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        cnt_d = cnt_q - 1'b1;
      end
      // Write lands behind whatever survives the pop this cycle.
      if (push_i && int'(cnt_d) < DEPTH) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == cnt_d) mem_d[i] = data_i;
        cnt_d = cnt_d + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_o     = mem_q[0];
  assign head_vld_o = cnt_q != '0;
  assign count_o    = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage for the 16-bit MIPS core. Owns the PC,
// reads a synchronous instruction ROM, buffers words in fetch_fifo and
// hands {ir, ir_pc} to decode over valid/ready.
// Ports:
//   clock, reset_n            clock / async active-low reset
//   imem_req, imem_addr       ROM read enable and word address
//   imem_data                 ROM data, valid the cycle after imem_req
//   redirect_valid/_pc        load a new PC and flush everything in flight
//   ir_valid, ir_ready        decode handshake
//   ir, ir_pc                 head instruction and its byte PC
// Optional (macro FETCH_PERF_EN):
//   perf_fetched              words pushed into the buffer (wraps)
//   perf_flushed              buffered + in-flight words dropped by redirects
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int IMEM_AW    = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_flushed
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int CW1    = CNT_W + 1;
  localparam int DATA_W = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q;
  logic              rsp_vld_q;
  logic              push, pop;
  logic [CNT_W-1:0]  occ;
  logic [CW1-1:0]    credit_used;
  logic [DATA_W-1:0] head;

  assign pop  = ir_valid & ir_ready;
  // A response arriving in a redirect cycle belongs to the old stream.
  assign push = rsp_vld_q & ~redirect_valid;

  // Slots already claimed once this cycle's pop retires. pop implies
  // occ >= 1, so this never underflows.
  assign credit_used = CW1'(occ) + CW1'(rsp_vld_q) - CW1'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    imem_req   = (state_q == RUN) & ~redirect_valid &
                 (int'(credit_used) < FIFO_DEPTH);
    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (push && is_halt(imem_data[INSTR_W-1 -: 4])) state_d = HALTED;
      HALTED:  if (redirect_valid) state_d = RUN;
      default: state_d = IDLE;
    endcase
    // Masking bit 0 (rather than slicing) keeps every redirect_pc bit used.
    if (redirect_valid)
      fetch_pc_d = redirect_pc & ~ADDR_W'(1);
    else if (imem_req)
      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      rsp_pc_q   <= '0;
      rsp_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      // imem_req is already low during a redirect, which clears it.
      rsp_vld_q  <= imem_req;
      if (imem_req) rsp_pc_q <= fetch_pc_q;
    end
  end

  assign imem_addr = fetch_pc_q[IMEM_AW:1];

  fetch_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_i     (push),
    .data_i     ({imem_data, rsp_pc_q}),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .head_o     (head),
    .head_vld_o (ir_valid),
    .count_o    (occ)
  );

  assign ir    = head[DATA_W-1 -: INSTR_W];
  assign ir_pc = head[ADDR_W-1:0];

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_flushed_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (push) perf_fetched_q <= perf_fetched_q + 16'd1;
      if (redirect_valid)
        perf_flushed_q <= perf_flushed_q + 16'(occ) + 16'(rsp_vld_q);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  localparam int ADDR_W  = 16;
  localparam int IMEM_AW = 10;
  localparam int DEPTH   = 2;
  localparam int ROM_N   = 1 << IMEM_AW;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               imem_req;
  logic [IMEM_AW-1:0] imem_addr;
  logic [15:0]        imem_data = '0;
  logic               redirect_valid = 1'b0;
  logic [15:0]        redirect_pc = '0;
  logic               ir_valid;
  logic               ir_ready = 1'b1;
  logic [15:0]        ir, ir_pc;
`ifdef FETCH_PERF_EN
  logic [15:0]        perf_fetched, perf_flushed;
`endif

  logic [15:0] rom [ROM_N];
  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Synchronous ROM: data appears the cycle after the request.
  always @(posedge clock) if (imem_req) imem_data <= rom[imem_addr];

  inst_fetch_unit #(.ADDR_W(ADDR_W), .IMEM_AW(IMEM_AW), .FIFO_DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir             (ir),
    .ir_pc          (ir_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushed   (perf_flushed)
`endif
  );

  typedef struct {
    bit          restart;
    bit          rdy;
    bit          rv;
    logic [15:0] rpc;
    bit          e_req;
    logic [15:0] e_addr;
    bit          e_vld;
    logic [15:0] e_ir;
    logic [15:0] e_pc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rs, bit rdy, bit rv, logic [15:0] rpc, bit rq,
                              logic [15:0] a, bit v, logic [15:0] i, logic [15:0] p);
    vec_t t;
    t.restart = rs; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.e_req = rq;
    t.e_addr = a; t.e_vld = v; t.e_ir = i; t.e_pc = p;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic init_rom();
    for (int i = 0; i < ROM_N; i++) rom[i] = {4'h1, 12'(i)};
    rom[0] = 16'h4100; rom[1] = 16'h4207; rom[2] = 16'h26C0; rom[3] = 16'h1780;
  endtask

  // Leaves reset released at a negedge; the next posedge is edge 0.
  task automatic do_reset(input bit check);
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b1;
    @(negedge clock);
    if (check) begin
      chk("rst imem_req", imem_req, 0);
      chk("rst imem_addr", imem_addr, 0);
      chk("rst ir_valid", ir_valid, 0);
      chk("rst ir", ir, 0);
      chk("rst ir_pc", ir_pc, 0);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic step(input bit rdy, input bit rv, input logic [15:0] rpc);
    @(posedge clock); #1;
    ir_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      vec_t v;
      v = tbl[i];
      if (v.restart) do_reset(1'b0);
      step(v.rdy, v.rv, v.rpc);
      chk($sformatf("row%0d imem_req", i), imem_req, v.e_req);
      if (v.e_req) chk($sformatf("row%0d imem_addr", i), imem_addr, v.e_addr);
      chk($sformatf("row%0d ir_valid", i), ir_valid, v.e_vld);
      if (v.e_vld) begin
        chk($sformatf("row%0d ir", i), ir, v.e_ir);
        chk($sformatf("row%0d ir_pc", i), ir_pc, v.e_pc);
      end
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    int got;
    logic [15:0] q_pc[$];
    logic [15:0] q_ir[$];

    init_rom();
    // Back-to-back delivery from reset (rows 0-5).
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 16'h4100, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 0, 1, 3, 1, 16'h4207, 16'h0002));
    tbl.push_back(mk(0, 1, 0, 0, 1, 4, 1, 16'h26C0, 16'h0004));
    tbl.push_back(mk(0, 1, 0, 0, 1, 5, 1, 16'h1780, 16'h0006));
    // Redirect to odd 0x0011 in cycle 4 (rows 6-13).
    tbl.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 2, 1, 16'h4100, 16'h0000));
    tbl.push_back(mk(0, 1, 1, 16'h0011, 0, 0, 1, 16'h4207, 16'h0002));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 9, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 10, 1, 16'h1008, 16'h0010));
    tbl.push_back(mk(0, 1, 0, 0, 1, 11, 1, 16'h1009, 16'h0012));

    do_reset(1'b1);
    run_rows(0, tbl.size() - 1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 4);
    chk("perf_flushed", perf_flushed, 2);
`endif

    // Backpressure: decode stalls cycles 3-8.
    do_reset(1'b0);
    reqs = 0;
    for (int c = 1; c <= 8; c++) begin
      step(c < 3, 1'b0, 16'h0);
      if (imem_req) reqs++;
      if (c == 3 || c == 8) begin
        chk($sformatf("stall c%0d ir", c), ir, 16'h4100);
        chk($sformatf("stall c%0d ir_pc", c), ir_pc, 16'h0000);
      end
    end
    chk("stall request count", reqs, 2);
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      step(1'b1, 1'b0, 16'h0);
      if (ir_valid) begin
        chk($sformatf("release pc%0d", got), ir_pc, 16'(2 * got));
        chk($sformatf("release ir%0d", got), ir, rom[got]);
        got++;
      end
    end
    chk("release delivered", got, 5);

    // HALT at word 2.
    rom[2] = 16'hF000;
    do_reset(1'b0);
    reqs = 0;
    q_pc.delete();
    for (int c = 1; c <= 12; c++) begin
      step(1'b1, 1'b0, 16'h0);
      if (c >= 5 && imem_req) reqs++;
      if (ir_valid) q_pc.push_back(ir_pc);
    end
    chk("halt reqs after halt", reqs, 0);
    chk("halt delivered count", q_pc.size(), 4);
    for (int i = 0; i < q_pc.size() && i < 4; i++)
      chk($sformatf("halt pc%0d", i), q_pc[i], 16'(2 * i));
    step(1'b1, 1'b1, 16'h0000);
    chk("halt redirect cycle req", imem_req, 0);
    step(1'b1, 1'b0, 16'h0);
    chk("halt resume req", imem_req, 1);
    chk("halt resume addr", imem_addr, 0);
    rom[2] = 16'h26C0;

    // Asynchronous reset mid-stream, then the reset timing again.
    do_reset(1'b0);
    for (int c = 1; c <= 4; c++) step(1'b1, 1'b0, 16'h0);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("async imem_req", imem_req, 0);
    chk("async imem_addr", imem_addr, 0);
    chk("async ir_valid", ir_valid, 0);
    chk("async ir", ir, 0);
    chk("async ir_pc", ir_pc, 0);
    run_rows(0, 5);

    // PC wrap from 0xFFFE.
    do_reset(1'b0);
    for (int c = 1; c <= 3; c++) step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 16'hFFFE);
    q_pc.delete(); q_ir.delete();
    for (int c = 0; c < 20 && q_pc.size() < 3; c++) begin
      step(1'b1, 1'b0, 16'h0);
      if (ir_valid) begin q_pc.push_back(ir_pc); q_ir.push_back(ir); end
    end
    chk("wrap delivered", q_pc.size(), 3);
    if (q_pc.size() == 3) begin
      chk("wrap pc0", q_pc[0], 16'hFFFE); chk("wrap ir0", q_ir[0], rom[ROM_N-1]);
      chk("wrap pc1", q_pc[1], 16'h0000); chk("wrap ir1", q_ir[1], rom[0]);
      chk("wrap pc2", q_pc[2], 16'h0002); chk("wrap ir2", q_ir[2], rom[1]);
    end

    // Random traffic against a stream-level model: requests and deliveries
    // must each walk a contiguous PC sequence from the last redirect target.
    begin
      logic [15:0] exp_dpc, iss_pc;
      bit rv, prev_rv, halt_req, halt_dl;
      int post_req, post_dl, issued, delivered, total;
      for (int i = 0; i < ROM_N; i++) rom[i] = 16'($urandom);
      do_reset(1'b0);
      exp_dpc = 0; iss_pc = 0; prev_rv = 0; halt_req = 0; halt_dl = 0;
      post_req = 0; post_dl = 0; issued = 0; delivered = 0; total = 0;
      for (int c = 0; c < 3000; c++) begin
        rv = ($urandom_range(0, 19) == 0);
        step($urandom_range(0, 9) < 7, rv, 16'($urandom));
        if (prev_rv) chk("rnd ir_valid after redirect", ir_valid, 0);
        if (rv) begin
          chk("rnd req in redirect", imem_req, 0);
          exp_dpc = redirect_pc & 16'hFFFE; iss_pc = exp_dpc;
          halt_req = 0; halt_dl = 0; post_req = 0; post_dl = 0;
          issued = 0; delivered = 0;
        end else begin
          if (imem_req) begin
            chk("rnd imem_addr", imem_addr, iss_pc[IMEM_AW:1]);
            if (halt_req) begin
              post_req++;
              chk("rnd reqs past halt ok", post_req <= 1, 1);
            end
            if (rom[iss_pc[IMEM_AW:1]][15:12] == 4'hF) halt_req = 1;
            iss_pc += 16'd2; issued++;
          end
          if (ir_valid && ir_ready) begin
            chk("rnd ir_pc", ir_pc, exp_dpc);
            chk("rnd ir", ir, rom[exp_dpc[IMEM_AW:1]]);
            if (halt_dl) begin
              post_dl++;
              chk("rnd words past halt ok", post_dl <= 1, 1);
            end
            if (ir[15:12] == 4'hF) halt_dl = 1;
            exp_dpc += 16'd2; delivered++; total++;
          end
          chk("rnd credit ok", (issued - delivered) <= DEPTH, 1);
        end
        prev_rv = rv;
      end
      chk("rnd progress ok", total > 200, 1);
    end

    redirect_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
